// File: rtl/physical_transmitter.sv
// QPSK baseband transmitter: SOF preamble + payload + zero gap, Gray-mapped I/Q held SPS samples.
// Optional TX_UNDERRUN_PAD_EN: pad starved payload fetches with symbol 00 and flag a sticky underrun.
module physical_transmitter #(
  parameter int unsigned SPS         = 8,
  parameter int unsigned AMP         = 512,
  parameter int unsigned PAYLOAD_LEN = 63,
  parameter int unsigned GAP_SYMBOLS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
`ifdef TX_UNDERRUN_PAD_EN
  output logic        underrun,
`endif
  output logic        busy
);

  localparam int unsigned SOF_LEN = 26;
  localparam int unsigned SPS_W   = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int unsigned MAX_SYM = (PAYLOAD_LEN > SOF_LEN) ? PAYLOAD_LEN : SOF_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_SYM + GAP_SYMBOLS + 1);

  localparam logic [25:0] SOF_I = 26'h3278428;
  localparam logic [25:0] SOF_Q = 26'h272d17d;
  localparam logic [11:0] AMP_P = 12'(AMP);
  localparam logic [11:0] AMP_N = 12'(0 - AMP);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PREAMBLE = 2'd1;
  localparam logic [1:0] PAYLOAD  = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [SPS_W-1:0] sps_cnt, sps_nxt;
  logic [CNT_W-1:0] sym_cnt, sym_nxt;
  logic [1:0]       cur_sym, cur_nxt;
  logic             out_valid_nxt, busy_nxt;
  logic [23:0]      out_data_nxt;
  logic             advance, last_sample, fetch_ok;
  logic [1:0]       fetch_sym;
  logic [4:0]       sof_idx;
`ifdef TX_UNDERRUN_PAD_EN
  logic             underrun_nxt;
`endif

  function automatic logic [23:0] map_sym(input logic neg_i, input logic neg_q);
    map_sym = {(neg_i ? AMP_N : AMP_P), (neg_q ? AMP_N : AMP_P)};
  endfunction

  assign advance     = ~out_valid | out_ready;
  assign last_sample = (sps_cnt == SPS_W'(SPS - 1));
  assign sof_idx     = 5'(5'd25 - 5'(sym_cnt));
  // Handshake offered only at a symbol fetch the output stage can take
  assign in_ready    = ~rst & (state == PAYLOAD) & (sps_cnt == '0) & advance;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sps_cnt   <= '0;
      sym_cnt   <= '0;
      cur_sym   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
`ifdef TX_UNDERRUN_PAD_EN
      underrun  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      sps_cnt   <= sps_nxt;
      sym_cnt   <= sym_nxt;
      cur_sym   <= cur_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      busy      <= busy_nxt;
`ifdef TX_UNDERRUN_PAD_EN
      underrun  <= underrun_nxt;
`endif
    end
  end

  // Payload fetch source: live input, or pad when starved and padding is enabled
  always_comb begin
    fetch_sym = in_data;
    fetch_ok  = in_valid;
`ifdef TX_UNDERRUN_PAD_EN
    if (!in_valid) begin
      fetch_sym = 2'b00;
      fetch_ok  = 1'b1;
    end
`endif
  end

  // Next-state and output-stage load
  always_comb begin
    state_nxt     = state;
    sps_nxt       = sps_cnt;
    sym_nxt       = sym_cnt;
    cur_nxt       = cur_sym;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
`ifdef TX_UNDERRUN_PAD_EN
    underrun_nxt  = underrun;
`endif
    if (advance) out_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = PREAMBLE;
          sps_nxt   = '0;
          sym_nxt   = '0;
        end
      end
      PREAMBLE: begin
        if (advance) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = map_sym(~SOF_I[sof_idx], ~SOF_Q[sof_idx]);
          sps_nxt       = last_sample ? '0 : sps_cnt + 1'b1;
          if (last_sample) begin
            if (sym_cnt == CNT_W'(SOF_LEN - 1)) begin
              state_nxt = PAYLOAD;
              sym_nxt   = '0;
            end else begin
              sym_nxt = sym_cnt + 1'b1;
            end
          end
        end
      end
      PAYLOAD: begin
        if (advance) begin
          if (sps_cnt == '0) begin
            if (fetch_ok) begin
              cur_nxt       = fetch_sym;
              out_valid_nxt = 1'b1;
              out_data_nxt  = map_sym(fetch_sym[1], fetch_sym[0]);
              sps_nxt       = SPS_W'(1);
`ifdef TX_UNDERRUN_PAD_EN
              if (!in_valid) underrun_nxt = 1'b1;
`endif
            end
          end else begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = map_sym(cur_sym[1], cur_sym[0]);
            sps_nxt       = last_sample ? '0 : sps_cnt + 1'b1;
            if (last_sample) begin
              if (sym_cnt == CNT_W'(PAYLOAD_LEN - 1)) begin
                state_nxt = (GAP_SYMBOLS > 0) ? GAP : IDLE;
                sym_nxt   = '0;
              end else begin
                sym_nxt = sym_cnt + 1'b1;
              end
            end
          end
        end
      end
      default: begin
        if (advance) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = '0;
          sps_nxt       = last_sample ? '0 : sps_cnt + 1'b1;
          if (last_sample) begin
            if (sym_cnt == CNT_W'(GAP_SYMBOLS - 1)) begin
              state_nxt = IDLE;
              sym_nxt   = '0;
            end else begin
              sym_nxt = sym_cnt + 1'b1;
            end
          end
        end
      end
    endcase

    // Busy until the frame is over and its last sample has left the output stage
    busy_nxt = (state_nxt != IDLE) | out_valid_nxt;
  end

endmodule

// File: tb/tb_physical_transmitter.sv
// Scoreboard bench for physical_transmitter: expected samples queued per frame, popped on accept.
module tb_physical_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        busy;
`ifdef TX_UNDERRUN_PAD_EN
  logic        underrun;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [23:0] exp_q[$];
  logic        rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data  = '0;
  logic [25:0] sof_i = 26'h3278428;
  logic [25:0] sof_q = 26'h272d17d;
  logic [1:0]  syms[63];

  physical_transmitter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef TX_UNDERRUN_PAD_EN
    .underrun(underrun),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] sample(input logic neg_i, input logic neg_q);
    int iv = neg_i ? -512 : 512;
    int qv = neg_q ? -512 : 512;
    return {12'(iv), 12'(qv)};
  endfunction

  // Monitor: hold-stability while stalled, and in-order match against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_sample", 32'(out_data), 32'hFFFF_FFFF);
        else check("sample", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic push_preamble();
    for (int k = 0; k < 26; k++)
      for (int s = 0; s < 8; s++) exp_q.push_back(sample(~sof_i[25-k], ~sof_q[25-k]));
  endtask

  task automatic push_frame();
    push_preamble();
    for (int k = 0; k < 63; k++)
      for (int s = 0; s < 8; s++) exp_q.push_back(sample(syms[k][1], syms[k][0]));
    for (int s = 0; s < 32; s++) exp_q.push_back(24'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Drive one frame of syms; keep holds in_valid high for a back-to-back start
  task automatic send_frame(input string tag, input bit chk_timing, input int drop_at, input bit keep);
    int idx = 0, n = 0, last_hs = 0;
    bit hs, dropped = 0;
    push_frame();
    in_data  = syms[0];
    in_valid = 1'b1;
    while (idx < 63 && n < 20000) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      if (hs && chk_timing && idx > 0) check({tag, "_ready_spacing"}, 32'(cyc - last_hs), 32'd8);
      if (hs) last_hs = cyc;
      @(posedge clk); #1; n++;
      if (chk_timing && n == 1) check({tag, "_lat_cycle1"}, 32'(out_valid), 32'd0);
      if (chk_timing && n == 2) check({tag, "_lat_cycle2"}, 32'(out_valid), 32'd1);
      if (hs) begin
        idx++;
        if (idx < 63) in_data = syms[idx];
        if (idx == drop_at && !dropped) begin
          in_valid = 1'b0;
          repeat (20) @(posedge clk);
          #1;
          check({tag, "_valid_low_on_starve"}, 32'(out_valid), 32'd0);
          in_valid = 1'b1;
          dropped  = 1;
        end
      end
    end
    check({tag, "_symbols_taken"}, 32'(idx), 32'd63);
    if (!keep) begin
      in_valid = 1'b0;
      wait_idle(tag);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero payload, full-rate sink
    for (int k = 0; k < 63; k++) syms[k] = 2'b00;
    send_frame("zeros", 1, -1, 0);

    // Gray mapping pattern under random backpressure
    for (int k = 0; k < 63; k++) begin
      case (k % 4)
        0: syms[k] = 2'b00;
        1: syms[k] = 2'b10;
        2: syms[k] = 2'b11;
        default: syms[k] = 2'b01;
      endcase
    end
    rand_ready = 1'b1;
    send_frame("gray_stall", 0, -1, 0);
    rand_ready = 1'b0;
    @(posedge clk); #1;

`ifndef TX_UNDERRUN_PAD_EN
    // Source starves for 20 cycles at payload symbol 10
    for (int k = 0; k < 63; k++) syms[k] = 2'($urandom_range(0, 3));
    send_frame("starve", 0, 10, 0);
`endif

    // Reset during preamble symbol 12 aborts the frame
    push_preamble();
    in_valid = 1'b1;
    repeat (2 + 12 * 8 + 3) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_stays_quiet", 32'(out_valid), 32'd0);

    // Restart after abort, then three back-to-back frames
    for (int k = 0; k < 63; k++) syms[k] = 2'($urandom_range(0, 3));
    send_frame("restart", 1, -1, 0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 63; k++) syms[k] = 2'($urandom_range(0, 3));
      send_frame("b2b", 0, -1, f < 2);
    end

`ifdef TX_UNDERRUN_PAD_EN
    check("no_underrun", 32'(underrun), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/physical_transmitter.md
Name: physical_transmitter

Overview:
QPSK baseband transmitter that is the peer of the physical receiver.
- Accepts a stream of 2-bit payload symbols.
- Builds each frame as a 26-symbol SOF preamble followed by 63 payload symbols.
- Gray-maps each symbol to signed I/Q at amplitude AMP and holds it for SPS samples (rectangular pulse).
- Emits packed {I[11:0], Q[11:0]} words toward the DAC / channel-model path.

Parameters:
SPS, 8, output samples per symbol (power of 2, 2..16)
AMP, 512, symbol amplitude in 2.10 fixed point (1..2047)
PAYLOAD_LEN, 63, payload symbols per frame
GAP_SYMBOLS, 4, zero-valued symbol periods between frames (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  payload symbol available
in_data  in  2  payload symbol (bit1 = I sign, bit0 = Q sign)
in_ready  out  1  symbol consumed this cycle (in_valid & in_ready)
out_valid  out  1  out_data holds a valid sample
out_ready  in  1  downstream accepts sample
out_data  out  24  {I[23:12], Q[11:0]}, signed 2.10
busy  out  1  high from leaving IDLE until the last gap sample is accepted

Behaviour:
Reset and interface:
- Reset: clk, rst synchronous active-high; state=IDLE, all counters 0, out_valid=0, out_data=0, in_ready=0, busy=0.
- Reset mid-frame aborts immediately. Nothing of the partial frame is emitted after rst deasserts.

Output stage:
- Single registered stage. It advances when (~out_valid | out_ready).
- out_data and out_valid must stay stable while out_valid & ~out_ready.

Symbol mapping:
- I = bit1 ? -AMP : +AMP; Q = bit0 ? -AMP : +AMP.
- Mapping is 00->(+,+), 10->(-,+), 11->(-,-), 01->(+,-).
- Zero symbol emits I=Q=0.

Counters:
- sps_cnt counts 0..SPS-1 on each advance.
- sym_cnt counts symbols within the current state.

FSM:
- IDLE:
  - out_valid=0.
  - On in_valid=1, go to PREAMBLE with sym_cnt=0. No symbol is consumed.
- PREAMBLE, 26 symbols:
  - Symbol k (k=0..25): I sign from SOF_I=26'h3278428 bit(25-k), Q sign from SOF_Q=26'h272d17d bit(25-k). MSB is sent first.
  - Bit value 1 means +AMP, 0 means -AMP.
  - Each symbol is held SPS samples.
  - After the last sample of k=25 is loaded, go to PAYLOAD with sym_cnt=0.
- PAYLOAD:
  - A symbol is fetched whenever sps_cnt==0 would be loaded into the output stage.
  - in_ready=1 only in that cycle, and only when the output stage can advance. It is combinational from state, sps_cnt and out_ready.
  - If in_valid=0 at fetch, no sample is loaded (out_valid drops after the current sample drains). Retry each cycle.
  - After PAYLOAD_LEN symbols have been fully emitted: go to GAP if GAP_SYMBOLS>0, else straight to IDLE.
- GAP:
  - Emits GAP_SYMBOLS*SPS zero samples with out_valid=1, then goes to IDLE.
- Back-to-back frames: from IDLE, a pending in_valid starts the next preamble on the next cycle.

Timing:
- Latency: first preamble sample is out_valid on the 2nd cycle after in_valid rises in IDLE (assuming out_ready=1).
- Frame length: (26+PAYLOAD_LEN+GAP_SYMBOLS)*SPS accepted samples; 744 with defaults.

Optional Feature:
Macro TX_UNDERRUN_PAD_EN.
- Defined: in PAYLOAD, if in_valid=0 at a fetch, a pad symbol 00 is transmitted instead of stalling. It counts toward PAYLOAD_LEN.
- Sticky output port underrun (1 bit) goes high and stays high until rst.
- Not defined: the stall behaviour above applies, and the underrun port does not exist.

Test Plan:
- Single frame, 63 symbols all 00, out_ready=1 -> 208 preamble samples, first 8 are I=+512,Q=+512 (SOF_I[25]=1, SOF_Q[25]=1). Next 504 samples are (512,512), then 32 zero samples. Exactly 63 in_ready pulses, spaced 8 cycles apart.
- Payload pattern 00,10,11,01 repeated -> per 8-sample group (512,512),(-512,512),(-512,-512),(512,-512). Loopback into physical_receiver recovers the same dibits.
- out_ready toggled randomly 50% -> out_data stable while stalled. Sample sequence identical to the unstalled run, no loss or duplication.
- in_valid dropped for 20 cycles at payload symbol 10 -> without macro: out_valid low during the gap, then symbol 10 resumes and the total stays 63. With TX_UNDERRUN_PAD_EN: pad (512,512) samples are inserted, underrun=1.
- rst asserted at preamble symbol 12 for 1 cycle -> next cycle out_valid=0, in_ready=0, busy=0. A new in_valid restarts with preamble symbol 0.
- Continuous in_valid over 3 frames -> each frame begins with the full 26-symbol preamble after the 4-symbol gap. The receiver asserts found_sof once per frame.
